// File: rtl/mbq_arb_pkg.sv
// Shared definitions for the multibuffer_queue write arbiter and its round-robin picker.
// Also usable by the read-side scheduler.
package mbq_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int STAT_WIDTH = 32;
  localparam int MAX_REQ    = 32;
  localparam int MAX_REQ_W  = 5;

  // One-hot of the first set bit of req at or after ptr, wrapping at n (n <= MAX_REQ).
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input int unsigned ptr,
                                                 input int unsigned n);
    logic [MAX_REQ-1:0] oh;
    logic               found;
    int unsigned        idx;
    oh    = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      if (k < n && !found) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (req[idx[MAX_REQ_W-1:0]]) begin
          oh[idx[MAX_REQ_W-1:0]] = 1'b1;
          found                  = 1'b1;
        end
      end
    end
    return oh;
  endfunction

endpackage

// File: rtl/mbq_write_arbiter_if.sv
// Producer-side and queue-side signals of the multibuffer_queue write arbiter.
interface mbq_write_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 128
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            grant;
  logic                          q_write_en;
  logic [DATA_WIDTH-1:0]         q_data_in;
  logic                          q_waitrequest;
  logic                          q_almost_full;
  logic                          busy;

  // Handshake: a producer beat transfers on a rising edge where req[i] && req_ready[i];
  // req/req_data must stay stable until then. The queue takes a write when
  // q_write_en && !q_waitrequest.
  modport master (
    input  req, req_data, q_waitrequest, q_almost_full,
    output req_ready, grant, q_write_en, q_data_in, busy
  );

  modport slave (
    output req, req_data, q_waitrequest, q_almost_full,
    input  req_ready, grant, q_write_en, q_data_in, busy
  );
endinterface

// File: rtl/mbq_rr_picker.sv
// Combinational cyclic first-one search: picks the first requester at or after ptr.
// Shared with the read-side scheduler.
module mbq_rr_picker
  import mbq_arb_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic [PTR_W-1:0]   pick_idx
);

  logic [MAX_REQ-1:0] oh;

  always_comb begin
    oh       = rr_pick(MAX_REQ'(req), 32'(ptr), NUM_REQ);
    pick     = oh[NUM_REQ-1:0];
    pick_idx = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (oh[k]) pick_idx = PTR_W'(k);
    end
  end

endmodule

// File: rtl/mbq_write_arbiter.sv
// Round-robin per-burst arbiter sharing the multibuffer_queue write port among NUM_REQ producers.
// Define MBQ_ARB_STATS_EN to add per-requester accepted-beat counters and a stall counter.
module mbq_write_arbiter
  import mbq_arb_pkg::*;
#(
  parameter int  NUM_REQ    = 4,
  parameter int  DATA_WIDTH = 128,
  parameter int  BURST_LEN  = 16,
  localparam int PTR_W      = $clog2(NUM_REQ),
  localparam int CNT_W      = $clog2(BURST_LEN + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  mbq_write_arbiter_if.master           bus,
  output arb_state_t                    dbg_state,
  output logic [PTR_W-1:0]              dbg_rr_ptr,
  output logic [CNT_W-1:0]              dbg_beat_cnt
`ifdef MBQ_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_WIDTH-1:0] stat_beats,
  output logic [STAT_WIDTH-1:0]         stat_stall
`endif
);

  arb_state_t         state, state_nxt;
  logic [NUM_REQ-1:0] grant_q, grant_nxt;
  logic [PTR_W-1:0]   owner_q, owner_nxt;
  logic [PTR_W-1:0]   rr_ptr, rr_nxt;
  logic [CNT_W-1:0]   beat_cnt, cnt_nxt;
  logic [NUM_REQ-1:0] pick;
  logic [PTR_W-1:0]   pick_idx;
  logic               accept;
  logic               burst_end;

  mbq_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req      (bus.req),
    .ptr      (rr_ptr),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant_q  <= grant_nxt;
      owner_q  <= owner_nxt;
      rr_ptr   <= rr_nxt;
      beat_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant_q;
    owner_nxt     = owner_q;
    rr_nxt        = rr_ptr;
    cnt_nxt       = beat_cnt;
    bus.req_ready = '0;
    bus.q_write_en = 1'b0;
    bus.busy      = 1'b0;
    accept        = 1'b0;
    burst_end     = 1'b0;
    case (state)
      IDLE: begin
        // almost_full only gates the start of a burst, never an ongoing one
        if (|bus.req && !bus.q_almost_full) begin
          state_nxt = GRANT;
          grant_nxt = pick;
          owner_nxt = pick_idx;
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        bus.busy                = 1'b1;
        bus.q_write_en          = bus.req[owner_q];
        accept                  = bus.req[owner_q] & ~bus.q_waitrequest;
        bus.req_ready[owner_q]  = accept;
        if (!bus.req[owner_q]) begin
          burst_end = 1'b1;
        end else if (accept) begin
          if (beat_cnt == CNT_W'(BURST_LEN - 1)) burst_end = 1'b1;
          else                                   cnt_nxt   = beat_cnt + 1'b1;
        end
        if (burst_end) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          cnt_nxt   = '0;
          rr_nxt    = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.q_data_in = bus.req_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
  assign bus.grant     = grant_q;
  assign dbg_state     = state;
  assign dbg_rr_ptr    = rr_ptr;
  assign dbg_beat_cnt  = beat_cnt;

`ifdef MBQ_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_beats <= '0;
      stat_stall <= '0;
    end else begin
      if (accept)
        stat_beats[owner_q*STAT_WIDTH +: STAT_WIDTH] <=
          stat_beats[owner_q*STAT_WIDTH +: STAT_WIDTH] + 1'b1;
      if (state == GRANT && bus.req[owner_q] && bus.q_waitrequest)
        stat_stall <= stat_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mbq_write_arbiter.sv
// Self-checking bench for mbq_write_arbiter: producer model, beat and burst scoreboards.
// Build with MBQ_ARB_STATS_EN defined to also check the statistics counters.
module tb_mbq_write_arbiter;
  import mbq_arb_pkg::*;

  localparam int NUM_REQ   = 4;
  localparam int DW        = 32;
  localparam int BURST_LEN = 16;
  localparam int PTR_W     = 2;
  localparam int CNT_W     = 5;
  localparam logic [3:0] ANY_GAP = 4'hF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mbq_write_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW)) bus ();

  arb_state_t       dbg_state;
  logic [PTR_W-1:0] dbg_rr_ptr;
  logic [CNT_W-1:0] dbg_beat_cnt;
`ifdef MBQ_ARB_STATS_EN
  logic [NUM_REQ*32-1:0] stat_beats;
  logic [31:0]           stat_stall;
`endif

  mbq_write_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DW),
    .BURST_LEN  (BURST_LEN)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .dbg_state    (dbg_state),
    .dbg_rr_ptr   (dbg_rr_ptr),
    .dbg_beat_cnt (dbg_beat_cnt)
`ifdef MBQ_ARB_STATS_EN
    ,
    .stat_beats   (stat_beats),
    .stat_stall   (stat_stall)
`endif
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- producer model ----------------
  // Each producer emits {id, sequence number}; sent[] advances on observed handshakes.
  int              total[NUM_REQ];
  int              sent[NUM_REQ];
  int              pushed[NUM_REQ];
  int              exp_stat[NUM_REQ];
  int              exp_stall;
  logic [NUM_REQ-1:0] en;

  always_comb begin
    bus.req      = '0;
    bus.req_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req[i]                = en[i] && (sent[i] < total[i]);
      bus.req_data[i*DW +: DW]  = {8'(i), 24'(sent[i])};
    end
  end

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  logic [15:0]   exp_burst_q[$];   // {grant, idle gap before burst, accepted beats}

  logic [NUM_REQ-1:0] prev_g = '0;
  int                 cur_len = 0;
  int                 idle_cnt = 0;
  int                 obs_gap = 0;

  always @(negedge clk) begin
    logic [NUM_REQ-1:0] g;
    logic [DW-1:0]      e;
    logic [15:0]        ob, eb;
    g = bus.grant;
    if (g != '0 && prev_g == '0) begin
      obs_gap = (idle_cnt > 14) ? 14 : idle_cnt;
      cur_len = 0;
    end
    if (g != '0 && prev_g != '0 && g != prev_g) check("grant_switch", g, prev_g);
    if (bus.req_ready != '0) begin
      check("ready_owner", bus.req_ready, g);
      check("write_en", bus.q_write_en, 1'b1);
      if (exp_q.size() == 0) begin
        check("beat_unexp", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("beat_data", bus.q_data_in, e);
      end
      cur_len++;
      for (int i = 0; i < NUM_REQ; i++) if (bus.req_ready[i]) sent[i]++;
    end
    if (g == '0 && prev_g != '0) begin
      ob = {prev_g, 4'(obs_gap), 8'(cur_len)};
      if (exp_burst_q.size() == 0) begin
        check("burst_unexp", exp_burst_q.size(), 1);
      end else begin
        eb = exp_burst_q.pop_front();
        if (eb[11:8] == ANY_GAP) eb[11:8] = ob[11:8];
        check("burst", ob, eb);
      end
    end
    idle_cnt = (g == '0) ? idle_cnt + 1 : 0;
    prev_g   = g;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_beats(input int id, input int n);
    total[id] += n;
    en[id]     = 1'b1;
  endtask

  task automatic push_beats(input int id, input int n);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({8'(id), 24'(pushed[id])});
      pushed[id]++;
      exp_stat[id]++;
    end
  endtask

  task automatic push_burst(input logic [3:0] g, input logic [3:0] gap, input int len);
    exp_burst_q.push_back({g, gap, 8'(len)});
  endtask

  task automatic assert_reset();
    rst_n     = 1'b0;
    exp_stall = 0;
    for (int i = 0; i < NUM_REQ; i++) exp_stat[i] = 0;
  endtask

  task automatic drain(input string tag, input int budget);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || exp_burst_q.size() != 0) && c < budget) begin
      tick();
      c++;
    end
    check({tag, "_drain"}, exp_q.size() + exp_burst_q.size(), 0);
  endtask

  task automatic wait_sent(input string tag, input int id, input int target, input int budget);
    int c;
    c = 0;
    while (sent[id] < target && c < budget) begin
      tick();
      c++;
    end
    check({tag, "_wait"}, sent[id], target);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    en                = '0;
    bus.q_waitrequest = 1'b0;
    bus.q_almost_full = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      total[i]  = 0;
      pushed[i] = 0;
    end
    assert_reset();
    repeat (3) tick();
    check("rst_grant", bus.grant, 4'b0000);
    rst_n = 1'b1;
    tick();
    check("rst_state", dbg_state, IDLE);
    check("rst_rr", dbg_rr_ptr, 2'd0);
    check("rst_cnt", dbg_beat_cnt, 5'd0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_wr_en", bus.q_write_en, 1'b0);
    check("rst_ready", bus.req_ready, 4'b0000);

    // Single requester, 40 beats: bursts 16/16/8 separated by one idle cycle
    push_beats(2, 40);
    push_burst(4'b0100, ANY_GAP, 16);
    push_burst(4'b0100, 4'd1, 16);
    push_burst(4'b0100, 4'd1, 8);
    add_beats(2, 40);
    drain("s1", 200);
    check("s1_rr", dbg_rr_ptr, 2'd3);
    en = '0;

    // All four requesting out of reset: order 0,1,2,3,0 with pointer wrap
    tick();
    assert_reset();
    for (int r = 0; r < 5; r++) begin
      push_beats(r % NUM_REQ, 16);
      push_burst(4'(1 << (r % NUM_REQ)), (r == 0) ? ANY_GAP : 4'd1, 16);
    end
    add_beats(0, 32);
    for (int i = 1; i < NUM_REQ; i++) add_beats(i, 16);
    repeat (2) tick();
    rst_n = 1'b1;
    drain("s2", 300);
    check("s2_rr", dbg_rr_ptr, 2'd1);
`ifdef MBQ_ARB_STATS_EN
    for (int i = 0; i < NUM_REQ; i++)
      check($sformatf("s2_stat_beats%0d", i), stat_beats[i*32 +: 32], 32'(exp_stat[i]));
`endif
    en = '0;

    // Wait-request stall of 5 cycles after beat 7
    base = sent[1];
    push_beats(1, 16);
    push_burst(4'b0010, ANY_GAP, 16);
    add_beats(1, 16);
    wait_sent("s3", 1, base + 7, 100);
    bus.q_waitrequest = 1'b1;
    exp_stall += 5;
    for (int c = 0; c < 5; c++) begin
      #2;
      check("s3_ready", bus.req_ready, 4'b0000);
      check("s3_cnt", dbg_beat_cnt, 5'd7);
      check("s3_grant", bus.grant, 4'b0010);
      check("s3_wr_en", bus.q_write_en, 1'b1);
      tick();
    end
    bus.q_waitrequest = 1'b0;
    drain("s3", 100);
`ifdef MBQ_ARB_STATS_EN
    check("s3_stat_stall", stat_stall, 32'(exp_stall));
    check("s3_stat_beats1", stat_beats[32 +: 32], 32'(exp_stat[1]));
`endif
    en = '0;

    // almost_full blocks new grants only
    bus.q_almost_full = 1'b1;
    base = sent[0];
    push_beats(0, 16);
    push_burst(4'b0001, ANY_GAP, 16);
    push_beats(1, 16);
    push_burst(4'b0010, ANY_GAP, 16);
    add_beats(0, 16);
    add_beats(1, 16);
    repeat (4) tick();
    check("s4_af_grant", bus.grant, 4'b0000);
    check("s4_af_state", dbg_state, IDLE);
    bus.q_almost_full = 1'b0;
    tick();
    check("s4_grant", bus.grant, 4'b0001);
    wait_sent("s4a", 0, base + 4, 50);
    bus.q_almost_full = 1'b1;
    wait_sent("s4b", 0, base + 16, 100);
    repeat (4) tick();
    check("s4_blocked_grant", bus.grant, 4'b0000);
    check("s4_blocked_busy", bus.busy, 1'b0);
    bus.q_almost_full = 1'b0;
    drain("s4", 100);
    en = '0;

    // Owner drops req after 3 beats; pointer wraps past requester 3
    push_beats(3, 3);
    push_burst(4'b1000, ANY_GAP, 3);
    add_beats(3, 3);
    drain("s5", 50);
    check("s5_rr", dbg_rr_ptr, 2'd0);
    en = '0;

    // Reset mid-burst: outputs clear immediately, burst is cut at 4 beats
    base = sent[2];
    push_beats(2, 4);
    push_burst(4'b0100, ANY_GAP, 4);
    add_beats(2, 10);
    wait_sent("s5r", 2, base + 4, 50);
    assert_reset();
    #1;
    check("s5r_grant", bus.grant, 4'b0000);
    check("s5r_wr_en", bus.q_write_en, 1'b0);
    check("s5r_busy", bus.busy, 1'b0);
    check("s5r_ready", bus.req_ready, 4'b0000);
    en = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    drain("s5r", 20);
    check("s5r_rr", dbg_rr_ptr, 2'd0);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
